branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  compare result and branch info present this cycle.
REQ-005 in_ready  output  1  block can accept; transfer occurs when in_valid & in_ready.
REQ-006 flag_z, flag_n, flag_v  input  1 each  zero, negative and overflow flags from the ALU SUB (A-B) operation.
REQ-007 sltu_bit  input  1  bit 0 of the ALU SLTU result for the same operands (1 = A < B unsigned).
REQ-008 funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010 and 011 are illegal.
REQ-009 pc, imm  input  32 each  branch instruction address and sign-extended offset.
REQ-010 pred_taken  input  1  fetch-stage prediction.
REQ-011 flush  input  1  synchronous kill of the held and incoming entries.
REQ-012 out_valid  output  1  resolved entry held.
REQ-013 out_ready  input  1  consumer accepts; output transfer occurs when out_valid & out_ready.
REQ-014 taken, redirect, illegal  output  1 each  resolved direction, mispredict flag and illegal-funct3 flag.
REQ-015 redirect_pc  output  32  correct next PC.
REQ-016 branch_cnt, mispred_cnt  output  16 each  saturating statistics counters.

Function
REQ-017 The block SHALL be a single-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 in_ready SHALL equal ~out_valid | out_ready, so accept-and-drain happens in one cycle without a bubble.
REQ-019 Latency SHALL be 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
REQ-020 taken SHALL be decoded as follows:
- BEQ: flag_z
- BNE: ~flag_z
- BLT: flag_n ^ flag_v
- BGE: ~(flag_n ^ flag_v)
- BLTU: sltu_bit
- BGEU: ~sltu_bit
REQ-021 redirect_pc SHALL be pc+imm when taken, otherwise pc+4; both sums are modulo 2^32 with the carry discarded.
REQ-022 redirect SHALL be taken ^ pred_taken for legal funct3.
REQ-023 For illegal funct3 the block SHALL register illegal=1, taken=0, redirect=0, redirect_pc=pc+4.
REQ-024 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Transitions SHALL be:
- EMPTY→FULL on an accept.
- FULL→EMPTY on an output transfer with no accept.
- FULL→FULL on an output transfer with a simultaneous accept; the new entry is loaded.
REQ-026 When flush=1 the next state SHALL be EMPTY regardless of in_valid or out_ready; the incoming entry is discarded and no counter is updated that cycle.
REQ-027 On each output transfer of a non-flushed entry:
- branch_cnt SHALL increment when illegal=0.
- mispred_cnt SHALL increment when redirect=1.
REQ-028 Both counters SHALL saturate at 0xFFFF.
REQ-029 in_valid with in_ready=0 SHALL be ignored; the source holds its data.

Reset
REQ-030 While rst_n=0 all registers SHALL clear asynchronously: out_valid=0, taken=0, redirect=0, illegal=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0.
REQ-031 After reset in_ready SHALL read 1.
REQ-032 Reset deasserted mid-operation SHALL discard any held entry without counting it.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-034 BEQ, flag_z=1, pc=0x100, imm=0x20, pred_taken=0, out_ready=1 -> next cycle out_valid=1, taken=1, redirect=1, redirect_pc=0x120; then branch_cnt=1, mispred_cnt=1.
REQ-035 BLT, flag_n=1, flag_v=1 -> taken=0, redirect_pc=pc+4; BGEU, sltu_bit=0 -> taken=1.
REQ-036 out_ready=0 with a held entry and a new in_valid -> in_ready=0, outputs unchanged for 3 cycles; raise out_ready -> held entry and new entry transfer on consecutive cycles, no gap.
REQ-037 pc=0xFFFFFFFC, not taken -> redirect_pc=0x00000000; pc=0xFFFFFFF0, imm=0x20, taken -> redirect_pc=0x00000010.
REQ-038 flush asserted with in_valid=1 while FULL -> out_valid=0 next cycle, counters unchanged.
REQ-039 funct3=010 -> illegal=1, redirect=0, branch_cnt unchanged.
REQ-040 Counters preloaded by 65535 mispredicting transfers -> both read 0xFFFF and stay there after a further transfer.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution stage: decodes ALU compare flags into a branch direction,
// computes the corrected next PC and holds the result in a single-entry output register.
module branch_resolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        sltu_bit,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        pred_taken,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic        redirect,
  output logic        illegal,
  output logic [31:0] redirect_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q;
  logic        taken_q;
  logic        redirect_q;
  logic        illegal_q;
  logic [31:0] redirect_pc_q;
  logic [15:0] branch_cnt_q;
  logic [15:0] mispred_cnt_q;

  logic        taken_d;
  logic        illegal_d;
  logic        redirect_d;
  logic [31:0] redirect_pc_d;
  logic        accept_s;
  logic        xfer_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  assign out_valid   = (state_q == FULL);
  assign in_ready    = ~out_valid | out_ready;
  assign accept_s    = in_valid & in_ready;
  assign xfer_s      = out_valid & out_ready;

  assign taken       = taken_q;
  assign redirect    = redirect_q;
  assign illegal     = illegal_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // Direction decode from the SUB/SLTU flags; illegal encodings resolve as not-taken.
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (funct3)
      3'b000:  taken_d = flag_z;
      3'b001:  taken_d = ~flag_z;
      3'b100:  taken_d = flag_n ^ flag_v;
      3'b101:  taken_d = ~(flag_n ^ flag_v);
      3'b110:  taken_d = sltu_bit;
      3'b111:  taken_d = ~sltu_bit;
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      redirect_d = 1'b0;
    end else begin
      redirect_d = taken_d ^ pred_taken;
    end
    redirect_pc_d = pc + (taken_d ? imm : 32'd4);
  end

  // Output register state machine and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= 32'd0;
      branch_cnt_q  <= 16'd0;
      mispred_cnt_q <= 16'd0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      if (xfer_s) begin
        if (!illegal_q) begin
          branch_cnt_q <= sat_inc(branch_cnt_q);
        end
        if (redirect_q) begin
          mispred_cnt_q <= sat_inc(mispred_cnt_q);
        end
      end
      if (accept_s) begin
        state_q       <= FULL;
        taken_q       <= taken_d;
        redirect_q    <= redirect_d;
        illegal_q     <= illegal_d;
        redirect_pc_q <= redirect_pc_d;
      end else if (xfer_s) begin
        state_q <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: operand-level reference model,
// directed corner cases and randomized traffic.
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flag_z, flag_n, flag_v, sltu_bit;
  logic [2:0]  funct3;
  logic [31:0] pc, imm;
  logic        pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken, redirect, illegal;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .sltu_bit(sltu_bit),
    .funct3(funct3), .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .redirect(redirect),
    .illegal(illegal), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // operands behind the flags currently driven
  logic [31:0] a_op, b_op;

  // reference model state
  logic        m_valid, m_taken, m_redirect, m_illegal;
  logic [31:0] m_rpc;
  logic [15:0] m_bcnt, m_mcnt;

  logic [31:0] saved_rpc;
  logic [15:0] saved_b, saved_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    ref_taken = (a == b);
      3'd1:    ref_taken = (a != b);
      3'd4:    ref_taken = ($signed(a) < $signed(b));
      3'd5:    ref_taken = ($signed(a) >= $signed(b));
      3'd6:    ref_taken = (a < b);
      3'd7:    ref_taken = (a >= b);
      default: ref_taken = 1'b0;
    endcase
  endfunction

  // drive a branch whose flags come from a real A-B subtraction
  task automatic set_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i, input logic pr);
    logic [31:0] d;
    d          = a - b;
    a_op       = a;
    b_op       = b;
    funct3     = f;
    pc         = p;
    imm        = i;
    pred_taken = pr;
    flag_z     = (d == 32'd0);
    flag_n     = d[31];
    flag_v     = (a[31] != b[31]) && (d[31] != a[31]);
    sltu_bit   = (a < b);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_taken = 1'b0; m_redirect = 1'b0; m_illegal = 1'b0;
    m_rpc = 32'd0; m_bcnt = 16'd0; m_mcnt = 16'd0;
  endtask

  task automatic check_all();
    logic exp_ir;
    exp_ir = !m_valid || out_ready;
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, exp_ir);
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
    if (m_valid) begin
      chk("taken", taken, m_taken);
      chk("redirect", redirect, m_redirect);
      chk("illegal", illegal, m_illegal);
      chk("redirect_pc", redirect_pc, m_rpc);
    end
  endtask

  // advance one clock: predict from the applied inputs, then compare after the edge
  task automatic step();
    logic ir, xfer, tk, il;
    ir = !m_valid || out_ready;
    if (flush) begin
      m_valid = 1'b0;
    end else begin
      xfer = m_valid && out_ready;
      if (xfer) begin
        if (!m_illegal && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
        if (m_redirect && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
      end
      if (in_valid && ir) begin
        il         = (funct3 == 3'd2) || (funct3 == 3'd3);
        tk         = ref_taken(funct3, a_op, b_op);
        m_taken    = tk;
        m_illegal  = il;
        m_redirect = il ? 1'b0 : (tk != pred_taken);
        m_rpc      = tk ? (pc + imm) : (pc + 32'd4);
        m_valid    = 1'b1;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_br(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_taken", taken, 1'b0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 16'd0);
    chk("rst_mispred_cnt", mispred_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken
    set_br(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("beq_valid", out_valid, 1'b1);
    chk("beq_taken", taken, 1'b1);
    chk("beq_redirect", redirect, 1'b1);
    chk("beq_rpc", redirect_pc, 32'h120);
    in_valid = 1'b0;
    step();
    chk("beq_bcnt", branch_cnt, 16'd1);
    chk("beq_mcnt", mispred_cnt, 16'd1);

    // BLT with N=1,V=1 (signed A >= B), then BGEU with A >= B unsigned
    set_br(3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h200, 32'h40, 1'b0);
    chk("blt_flags", {flag_n, flag_v}, 2'b11);
    in_valid = 1'b1;
    step();
    chk("blt_taken", taken, 1'b0);
    chk("blt_rpc", redirect_pc, 32'h204);
    set_br(3'd7, 32'd10, 32'd3, 32'h300, 32'h8, 1'b1);
    step();
    chk("bgeu_taken", taken, 1'b1);
    in_valid = 1'b0;
    step();

    // backpressure: held entry stays stable, then back-to-back drain
    out_ready = 1'b0;
    set_br(3'd1, 32'd1, 32'd2, 32'h400, 32'h10, 1'b0);
    in_valid = 1'b1;
    step();
    saved_rpc = redirect_pc;
    set_br(3'd6, 32'd1, 32'd2, 32'h500, 32'h30, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_rpc_stable", redirect_pc, saved_rpc);
    end
    out_ready = 1'b1;
    step();
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_rpc", redirect_pc, 32'h530);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 1'b0);

    // PC wraparound
    set_br(3'd1, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h100, 1'b0);
    in_valid = 1'b1;
    step();
    chk("wrap_nt_rpc", redirect_pc, 32'h0);
    set_br(3'd0, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h20, 1'b1);
    step();
    chk("wrap_t_rpc", redirect_pc, 32'h10);

    // flush while FULL with a new entry offered
    out_ready = 1'b0;
    step();
    saved_b = branch_cnt; saved_m = mispred_cnt;
    flush = 1'b1;
    step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_bcnt", branch_cnt, saved_b);
    chk("flush_mcnt", mispred_cnt, saved_m);
    flush = 1'b0;

    // illegal funct3
    out_ready = 1'b1;
    set_br(3'd2, 32'd1, 32'd1, 32'h600, 32'h40, 1'b1);
    step();
    saved_b = branch_cnt;
    chk("ill_flag", illegal, 1'b1);
    chk("ill_redirect", redirect, 1'b0);
    chk("ill_rpc", redirect_pc, 32'h604);
    in_valid = 1'b0;
    step();
    chk("ill_bcnt", branch_cnt, saved_b);

    // randomized traffic
    for (int r = 0; r < 400; r++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      set_br(3'($urandom_range(0, 7)), ra, rb, $urandom, $urandom, 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;

    // reset while holding an entry
    out_ready = 1'b0; in_valid = 1'b1;
    set_br(3'd0, 32'd1, 32'd2, 32'h700, 32'h4, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_bcnt", branch_cnt, 16'd0);
    chk("midrst_mcnt", mispred_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("first_accept", out_valid, 1'b1);

    // saturate both counters with mispredicting legal branches
    out_ready = 1'b1;
    repeat (65536) step();
    chk("sat_bcnt", branch_cnt, 16'hFFFF);
    chk("sat_mcnt", mispred_cnt, 16'hFFFF);
    repeat (2) step();
    chk("sat_hold_bcnt", branch_cnt, 16'hFFFF);
    chk("sat_hold_mcnt", mispred_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
